// File: rtl/display_timing.sv
// -----------------------------------------------------------------------------
// display_timing
//   Pixel-clock raster timing generator. It walks (sx, sy) over the full
//   H_TOTAL x V_TOTAL raster and produces the matching data-enable, sync and
//   start-of-line/frame strobes. Every output is decoded from the next-state
//   coordinates and registered with them, so all outputs in a given cycle
//   describe the same pixel.
//
//   Ports
//     pix_clk      in   1   pixel clock
//     pix_rstn     in   1   synchronous active-low reset
//     sx           out  16  horizontal position, 0..H_TOTAL-1
//     sy           out  16  vertical position, 0..V_TOTAL-1
//     de           out  1   visible-area enable
//     hsync        out  1   horizontal sync, asserted level H_SYNC_POL
//     vsync        out  1   vertical sync, asserted level V_SYNC_POL
//     line_start   out  1   high when sx == 0
//     frame_start  out  1   high when sx == 0 and sy == 0
//     frame_cnt    out  16  index of the current frame (wraps mod 2^16)
// -----------------------------------------------------------------------------
module display_timing #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter bit          H_SYNC_POL = 1'b0,
   parameter bit          V_SYNC_POL = 1'b0
) (
   input  logic        pix_clk,
   input  logic        pix_rstn,
   output logic [15:0] sx,
   output logic [15:0] sy,
   output logic        de,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
   localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
   localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
   localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

   logic [15:0] sx_q, sx_d;
   logic [15:0] sy_q, sy_d;
   logic        de_q, de_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        ls_q, ls_d;
   logic        fs_q, fs_d;
   logic [15:0] fcnt_q, fcnt_d;

   always_comb begin
      sx_d = sx_q + 16'd1;
      sy_d = sy_q;
      // >= rather than == so a stray out-of-range value still wraps cleanly
      if (sx_q >= H_LAST) begin
         sx_d = 16'd0;
         sy_d = (sy_q >= V_LAST) ? 16'd0 : sy_q + 16'd1;
      end

      // Decode from the next coordinates so the strobes land with them
      de_d    = (sx_d < H_ACT) && (sy_d < V_ACT);
      hsync_d = ((sx_d >= HS_BEG) && (sx_d < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_d = ((sy_d >= VS_BEG) && (sy_d < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
      ls_d    = (sx_d == 16'd0);
      fs_d    = (sx_d == 16'd0) && (sy_d == 16'd0);
      // Counter resets to FFFF so the first frame after reset is frame 0
      fcnt_d  = fs_d ? fcnt_q + 16'd1 : fcnt_q;
   end

   always_ff @(posedge pix_clk) begin
      if (!pix_rstn) begin
         // Park on the last pixel of a frame; the first advance yields (0,0)
         sx_q    <= H_LAST;
         sy_q    <= V_LAST;
         de_q    <= 1'b0;
         hsync_q <= ~H_SYNC_POL;
         vsync_q <= ~V_SYNC_POL;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
         fcnt_q  <= 16'hFFFF;
      end else begin
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         de_q    <= de_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign sx          = sx_q;
   assign sy          = sy_q;
   assign de          = de_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
   assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_display_timing.sv
// -----------------------------------------------------------------------------
// tb_display_timing
//   Three instances share one clock, each with its own reset:
//     A - default 640x480 timing (line timing, line wrap, mid-frame reset)
//     B - default horizontal timing, short 4/1/2/1 vertical (frame period,
//         vsync window, blanking-line de)
//     C - 7x5 raster with active-high syncs (pixel-exact frames, counter)
// -----------------------------------------------------------------------------
module tb_display_timing;

   typedef struct packed {
      logic [15:0] sx;
      logic [15:0] sy;
      logic        de;
      logic        hs;
      logic        vs;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } obs_t;

   typedef struct {
      int    adv;
      obs_t  exp;
      string nm;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstnA = 1'b0, rstnB = 1'b0, rstnC = 1'b0;

   logic [15:0] sxA, syA, fcA, sxB, syB, fcB, sxC, syC, fcC;
   logic        deA, hsA, vsA, lsA, fsA;
   logic        deB, hsB, vsB, lsB, fsB;
   logic        deC, hsC, vsC, lsC, fsC;
   obs_t        obsA, obsB, obsC;

   assign obsA = {sxA, syA, deA, hsA, vsA, lsA, fsA, fcA};
   assign obsB = {sxB, syB, deB, hsB, vsB, lsB, fsB, fcB};
   assign obsC = {sxC, syC, deC, hsC, vsC, lsC, fsC, fcC};

   display_timing u_a (
      .pix_clk(clk), .pix_rstn(rstnA), .sx(sxA), .sy(syA), .de(deA),
      .hsync(hsA), .vsync(vsA), .line_start(lsA), .frame_start(fsA),
      .frame_cnt(fcA));

   display_timing #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_b (
      .pix_clk(clk), .pix_rstn(rstnB), .sx(sxB), .sy(syB), .de(deB),
      .hsync(hsB), .vsync(vsB), .line_start(lsB), .frame_start(fsB),
      .frame_cnt(fcB));

   display_timing #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) u_c (
      .pix_clk(clk), .pix_rstn(rstnC), .sx(sxC), .sy(syC), .de(deC),
      .hsync(hsC), .vsync(vsC), .line_start(lsC), .frame_start(fsC),
      .frame_cnt(fcC));

   int checks = 0;
   int failures = 0;

   function automatic obs_t mk(int x, int y, bit d, bit h, bit v, bit l, bit f, int c);
      obs_t o;
      o.sx = 16'(x); o.sy = 16'(y); o.de = d; o.hs = h; o.vs = v;
      o.ls = l; o.fs = f; o.fc = 16'(c);
      return o;
   endfunction

   task automatic cmp(input string nm, input obs_t a, input obs_t e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%h, want sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%h",
                  nm, a.sx, a.sy, a.de, a.hs, a.vs, a.ls, a.fs, a.fc,
                  e.sx, e.sy, e.de, e.hs, e.vs, e.ls, e.fs, e.fc);
      end
   endtask

   task automatic chk_int(input string nm, input int a, input int e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", nm, a, e);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   vec_t tbl[13];

   initial begin
      int de_cnt, hs_lo, hs_first, hs_last, ls_cnt, seq_bad;
      int cyc, vs_lo, vs_fx, vs_fy, vs_lx, vs_ly, de_bad;
      bit found;

      // Default raster, walked from the first pixel after reset release
      tbl[0]  = '{1,    mk(0,   0,  1, 1, 1, 1, 1, 0), "first_pixel"};
      tbl[1]  = '{1,    mk(1,   0,  1, 1, 1, 0, 0, 0), "second_pixel"};
      tbl[2]  = '{638,  mk(639, 0,  1, 1, 1, 0, 0, 0), "last_active"};
      tbl[3]  = '{1,    mk(640, 0,  0, 1, 1, 0, 0, 0), "first_fp"};
      tbl[4]  = '{15,   mk(655, 0,  0, 1, 1, 0, 0, 0), "last_fp"};
      tbl[5]  = '{1,    mk(656, 0,  0, 0, 1, 0, 0, 0), "hsync_on"};
      tbl[6]  = '{95,   mk(751, 0,  0, 0, 1, 0, 0, 0), "hsync_last"};
      tbl[7]  = '{1,    mk(752, 0,  0, 1, 1, 0, 0, 0), "hsync_off"};
      tbl[8]  = '{47,   mk(799, 0,  0, 1, 1, 0, 0, 0), "line_end"};
      tbl[9]  = '{1,    mk(0,   1,  1, 1, 1, 1, 0, 0), "line1_start"};
      tbl[10] = '{7999, mk(799, 10, 0, 1, 1, 0, 0, 0), "line10_end"};
      tbl[11] = '{1,    mk(0,   11, 1, 1, 1, 1, 0, 0), "line11_start"};
      tbl[12] = '{1,    mk(1,   11, 1, 1, 1, 0, 0, 0), "line11_px1"};

      // Reset held for 10 cycles on all instances
      step(10);
      cmp("rst_a", obsA, mk(799, 524, 0, 1, 1, 0, 0, 16'hFFFF));
      cmp("rst_b", obsB, mk(799, 7,   0, 1, 1, 0, 0, 16'hFFFF));
      cmp("rst_c", obsC, mk(6,   4,   0, 0, 0, 0, 0, 16'hFFFF));

      // ---------------- A: table-driven line timing ----------------
      rstnA = 1'b1;
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].adv);
         cmp(tbl[i].nm, obsA, tbl[i].exp);
      end

      // Full scan of line 12
      step(799);
      de_cnt = 0; hs_lo = 0; hs_first = -1; hs_last = -1; ls_cnt = 0; seq_bad = 0;
      for (int i = 0; i < 800; i++) begin
         if (sxA != 16'(i) || syA != 16'd12) seq_bad++;
         if (deA) de_cnt++;
         if (!hsA) begin
            hs_lo++;
            if (hs_first < 0) hs_first = i;
            hs_last = i;
         end
         if (lsA) begin
            ls_cnt++;
            if (i != 0) seq_bad++;
         end
         if (deA != (i < 640)) seq_bad++;
         if (i < 799) step(1);
      end
      chk_int("line_seq_errors", seq_bad, 0);
      chk_int("line_de_count", de_cnt, 640);
      chk_int("line_hsync_low_count", hs_lo, 96);
      chk_int("line_hsync_first", hs_first, 656);
      chk_int("line_hsync_last", hs_last, 751);
      chk_int("line_start_count", ls_cnt, 1);

      // Mid-frame reset
      step(301);
      cmp("a_pre_reset", obsA, mk(300, 13, 1, 1, 1, 0, 0, 0));
      rstnA = 1'b0;
      step(1);
      cmp("a_midreset_1", obsA, mk(799, 524, 0, 1, 1, 0, 0, 16'hFFFF));
      step(2);
      cmp("a_midreset_3", obsA, mk(799, 524, 0, 1, 1, 0, 0, 16'hFFFF));
      rstnA = 1'b1;
      step(1);
      cmp("a_restart", obsA, mk(0, 0, 1, 1, 1, 1, 1, 0));

      // ---------------- B: frame period / vsync window ----------------
      rstnB = 1'b1;
      step(1);
      cmp("b_first", obsB, mk(0, 0, 1, 1, 1, 1, 1, 0));
      cyc = 0; vs_lo = 0; vs_fx = -1; vs_fy = -1; vs_lx = -1; vs_ly = -1;
      de_cnt = 0; de_bad = 0; found = 1'b0;
      while (!found && cyc < 20000) begin
         if (!vsB) begin
            vs_lo++;
            if (vs_fx < 0) begin vs_fx = int'(sxB); vs_fy = int'(syB); end
            vs_lx = int'(sxB); vs_ly = int'(syB);
         end
         if (deB) begin
            de_cnt++;
            if (syB >= 16'd4 || sxB >= 16'd640) de_bad++;
         end
         step(1);
         cyc++;
         if (fsB) found = 1'b1;
      end
      chk_int("b_frame_found", int'(found), 1);
      chk_int("b_frame_period", cyc, 6400);
      chk_int("b_vsync_low_cycles", vs_lo, 1600);
      chk_int("b_vsync_first_x", vs_fx, 0);
      chk_int("b_vsync_first_y", vs_fy, 5);
      chk_int("b_vsync_last_x", vs_lx, 799);
      chk_int("b_vsync_last_y", vs_ly, 6);
      chk_int("b_de_count", de_cnt, 2560);
      chk_int("b_de_in_blanking", de_bad, 0);
      cmp("b_frame1", obsB, mk(0, 0, 1, 1, 1, 1, 1, 1));

      // ---------------- C: small raster, pixel exact ----------------
      rstnC = 1'b1;
      step(1);
      for (int i = 0; i < 70; i++) begin
         int x, y;
         x = i % 7;
         y = (i / 7) % 5;
         cmp($sformatf("c_px%0d", i), obsC,
             mk(x, y, (x < 4) && (y < 2), x == 5, y == 3, x == 0, (i % 35) == 0, i / 35));
         step(1);
      end
      step(35 * 298);
      cmp("c_frame300", obsC, mk(0, 0, 1, 0, 0, 1, 1, 300));
      step(17);
      cmp("c_pre_reset", obsC, mk(3, 2, 0, 0, 0, 0, 0, 300));
      rstnC = 1'b0;
      step(1);
      cmp("c_midreset_1", obsC, mk(6, 4, 0, 0, 0, 0, 0, 16'hFFFF));
      step(2);
      cmp("c_midreset_3", obsC, mk(6, 4, 0, 0, 0, 0, 0, 16'hFFFF));
      rstnC = 1'b1;
      step(1);
      cmp("c_restart", obsC, mk(0, 0, 1, 0, 0, 1, 1, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
